// File: rtl/mono_data_rx.sv
// mono_data_rx
//   FPGA-side readout controller and deserializer for the monopix chip.
//   Watches the chip token, freezes the matrix, pulses READ once per hit,
//   deserializes the 30-bit MSB-first word from Data_Out and queues the
//   decoded words in a first-word fall-through FIFO for the DAQ.
//   Everything runs on the single readout clock (Clk_Out rate).
//
//   Optional build macro: MONO_DATA_RX_TIMESTAMP_EN
//     When defined, a 30-bit free-running counter is latched on every
//     IDLE->FREEZE transition and a {2'b01, ts} word is queued ahead of
//     the hit words of that readout sequence.
//
// Ports
//   clk         readout clock
//   rst         asynchronous active-high reset
//   enable      readout enable, only looked at while idle
//   token_out   chip Token_Out (asynchronous, synchronised here)
//   data_out    chip Data_Out serial bit
//   read        chip READ
//   freeze      chip FREEZE
//   fifo_data   head word of the output FIFO
//   fifo_valid  fifo_data holds a word
//   fifo_ready  consumer takes the word when fifo_valid && fifo_ready
//   lost_count  saturating count of words dropped on a full FIFO
//   busy        FSM is not idle
//
// Parameter notes: FREEZE_DLY >= 1, DATA_DLY >= 1,
//   FIFO_DEPTH a power of two >= 2.

module mono_data_rx #(
  parameter int FREEZE_DLY = 4,
  parameter int READ_LEN   = 2,
  parameter int DATA_DLY   = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        token_out,
  input  logic        data_out,
  output logic        read,
  output logic        freeze,
  output logic [31:0] fifo_data,
  output logic        fifo_valid,
  input  logic        fifo_ready,
  output logic [7:0]  lost_count,
  output logic        busy
);

  localparam int RAW_W     = 30;
  localparam int WORD_W    = 32;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int SHIFT_END = DATA_DLY + RAW_W - 1;
  localparam int CNT_MAX0  = (FREEZE_DLY > SHIFT_END) ? FREEZE_DLY : SHIFT_END;
  localparam int CNT_MAX   = (READ_LEN > CNT_MAX0) ? READ_LEN : CNT_MAX0;
  localparam int CNT_W     = $clog2(CNT_MAX + 1) + 1;

  localparam logic [CNT_W-1:0] FRZ_LAST  = CNT_W'(FREEZE_DLY - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(DATA_DLY - 1);
  localparam logic [CNT_W-1:0] SHF_LAST  = CNT_W'(SHIFT_END);
  localparam logic [CNT_W-1:0] RD_LEN    = CNT_W'(READ_LEN);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_READ,
    S_SHIFT,
    S_PUSH,
    S_CHECK
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              tok_p0, tok_p1, tok_s;
  logic [RAW_W-1:0]  raw_p0;
  logic              wr_req;
  logic [WORD_W-1:0] wr_word;

  // ---- token synchroniser: two flops, tok_s lags token_out by 2 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_p0 <= 1'b0;
      tok_p1 <= 1'b0;
    end else begin
      tok_p0 <= token_out;
      tok_p1 <= tok_p0;
    end
  end
  assign tok_s = tok_p1;

  // ---- readout FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // One counter spans READ and SHIFT: it starts at the READ rising edge,
  // so read length, data delay and bit position all index off it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_ONE;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (enable && tok_s) state_n = S_FREEZE;
      end
      S_FREEZE: begin
        if (cnt == FRZ_LAST) begin
          state_n = S_READ;
          cnt_n   = '0;
        end
      end
      S_READ: begin
        if (cnt == READ_LAST) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == SHF_LAST) begin
          state_n = S_PUSH;
          cnt_n   = '0;
        end
      end
      S_PUSH: begin
        state_n = S_CHECK;
        cnt_n   = '0;
      end
      S_CHECK: begin
        if (cnt == CHK_LAST) begin
          cnt_n   = '0;
          state_n = tok_s ? S_READ : S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Decoded straight from the state register so reset drops them at once.
  // read may extend into SHIFT when DATA_DLY < READ_LEN.
  assign busy   = (state != S_IDLE);
  assign freeze = busy;
  assign read   = ((state == S_READ) || (state == S_SHIFT)) && (cnt < RD_LEN);

  // ---- deserializer: MSB arrives first
  always_ff @(posedge clk) begin
    if (state == S_SHIFT) raw_p0 <= {raw_p0[RAW_W-2:0], data_out};
  end

`ifdef MONO_DATA_RX_TIMESTAMP_EN
  logic [RAW_W-1:0] ts_cnt;
  logic [RAW_W-1:0] ts_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 30'd1;
  end

  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && (state_n == S_FREEZE)) ts_cap <= ts_cnt;
  end

  // Timestamp word goes in on the first FREEZE cycle, ahead of any hit.
  always_comb begin
    wr_req  = (state == S_PUSH) || ((state == S_FREEZE) && (cnt == '0));
    wr_word = (state == S_PUSH) ? {2'b00, raw_p0} : {2'b01, ts_cap};
  end
`else
  always_comb begin
    wr_req  = (state == S_PUSH);
    wr_word = {2'b00, raw_p0};
  end
`endif

  // ---- output FIFO, first-word fall-through
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, wr_ok, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && fifo_ready;
  // A simultaneous pop frees the slot, so a write into a full FIFO still lands.
  assign wr_ok = wr_req && (!full || pop);
  assign drop  = wr_req && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lost_count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)  lost_count <= sat_inc8(lost_count);
    end
  end

  assign fifo_data  = mem[rd_ptr[AW-1:0]];
  assign fifo_valid = !empty;

endmodule

// File: tb/tb_mono_data_rx.sv
`timescale 1ns/1ps
module tb_mono_data_rx;

  localparam int FREEZE_DLY = 4;
  localparam int READ_LEN   = 2;
  localparam int DATA_DLY   = 10;
  localparam int FIFO_DEPTH = 16;
  localparam int HIT_CYC    = DATA_DLY + 30 + 1 + 3;
  localparam int HMAX       = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        token_out;
  logic        data_out;
  logic        read;
  logic        freeze;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;
  logic [7:0]  lost_count;
  logic        busy;

  always #5 clk = ~clk;

  mono_data_rx #(
    .FREEZE_DLY(FREEZE_DLY),
    .READ_LEN  (READ_LEN),
    .DATA_DLY  (DATA_DLY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .token_out (token_out),
    .data_out  (data_out),
    .read      (read),
    .freeze    (freeze),
    .fifo_data (fifo_data),
    .fifo_valid(fifo_valid),
    .fifo_ready(fifo_ready),
    .lost_count(lost_count),
    .busy      (busy)
  );

  // hits handed to the chip model (written by the main sequence only)
  logic [29:0] hit_mem [HMAX];
  int          n_hits = 0;
  int          n_reads = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [29:0] pend_q[$];
  int          lost_exp = 0;

  // monitor records
  int rd_len_q[$];
  int rd_off_q[$];
  int frz_len_q[$];
  int m_rl, m_ro, m_fl;

  logic [29:0] cyc;
  int total = 0;
  int bad   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 30'd1;
  end

  // chip model: token high while hits are pending; each READ rising edge
  // consumes one hit and returns it MSB first, DATA_DLY cycles later
  initial begin : chip_model
    logic        prev_rd;
    logic [29:0] raw;
    token_out = 1'b0;
    data_out  = 1'b0;
    prev_rd   = 1'b0;
    forever begin
      @(negedge clk);
      if (read && !prev_rd) begin
        raw = hit_mem[n_reads % HMAX];
        n_reads++;
        token_out = (n_reads < n_hits);
        repeat (DATA_DLY) @(negedge clk);
        for (int i = 29; i >= 0; i--) begin
          data_out = raw[i];
          @(negedge clk);
        end
        data_out = 1'b0;
      end
      prev_rd   = read;
      token_out = (n_reads < n_hits);
    end
  end

  // pulse monitor: READ pulse lengths, READ rise offset inside a freeze
  // episode, and freeze episode lengths
  initial begin : pulse_mon
    int   rl;
    int   fl;
    logic prev_rd;
    rl = 0;
    fl = 0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (freeze) fl++;
      if (read && !prev_rd) rd_off_q.push_back(fl);
      if (read) rl++;
      else if (rl != 0) begin
        rd_len_q.push_back(rl);
        rl = 0;
      end
      if (!freeze && fl != 0) begin
        frz_len_q.push_back(fl);
        fl = 0;
      end
      prev_rd = read;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic add_hit(input logic [29:0] r);
    hit_mem[n_hits % HMAX] = r;
    n_hits++;
    pend_q.push_back(r);
  endtask

  task automatic push_model(input logic [31:0] w);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(w);
    else if (lost_exp < 255) lost_exp++;
  endtask

  task automatic mark();
    m_rl = rd_len_q.size();
    m_ro = rd_off_q.size();
    m_fl = frz_len_q.size();
  endtask

  task automatic start_seq();
    int k = 0;
    while (!freeze && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("seq_start", {31'd0, freeze}, 32'd1);
`ifdef MONO_DATA_RX_TIMESTAMP_EN
    push_model({2'b01, cyc - 30'd1});
`endif
  endtask

  task automatic finish_seq();
    int k = 0;
    int lim;
    lim = pend_q.size() * HIT_CYC + 100;
    while (pend_q.size() != 0) push_model({2'b00, pend_q.pop_front()});
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("seq_done", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_seq();
    start_seq();
    finish_seq();
  endtask

  task automatic wait_read();
    int k = 0;
    while (!read && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("read_rise", {31'd0, read}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    fifo_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", {31'd0, fifo_valid}, 32'd1);
      chk("drain_data", fifo_data, exp_q[i]);
      @(negedge clk);
    end
    fifo_ready = 1'b0;
    chk("drain_empty", {31'd0, fifo_valid}, 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_pulses(input int nh);
    chk("read_count", rd_len_q.size() - m_rl, nh);
    for (int k = 0; k < nh; k++) begin
      if (rd_len_q.size() > m_rl + k) chk("read_len", rd_len_q[m_rl + k], READ_LEN);
      if (rd_off_q.size() > m_ro + k)
        chk("read_offset", rd_off_q[m_ro + k], FREEZE_DLY + 1 + k * HIT_CYC);
    end
    chk("freeze_episodes", frz_len_q.size() - m_fl, 1);
    if (frz_len_q.size() > m_fl) chk("freeze_len", frz_len_q[m_fl], FREEZE_DLY + nh * HIT_CYC);
  endtask

  initial begin : main_seq
    logic a_rd, a_fz, a_fv, a_bz;
    rst        = 1'b1;
    enable     = 1'b0;
    fifo_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read",   {31'd0, read},       32'd0);
    chk("rst_freeze", {31'd0, freeze},     32'd0);
    chk("rst_valid",  {31'd0, fifo_valid}, 32'd0);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_lost",   {24'd0, lost_count}, 32'd0);

    // enabled, no token: nothing may move
    rst    = 1'b0;
    enable = 1'b1;
    a_rd = 1'b0; a_fz = 1'b0; a_fv = 1'b0; a_bz = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a_rd |= read; a_fz |= freeze; a_fv |= fifo_valid; a_bz |= busy;
    end
    chk("idle_read",   {31'd0, a_rd}, 32'd0);
    chk("idle_freeze", {31'd0, a_fz}, 32'd0);
    chk("idle_valid",  {31'd0, a_fv}, 32'd0);
    chk("idle_busy",   {31'd0, a_bz}, 32'd0);

    // single hit
    mark();
    add_hit(30'h2AB3C14);
    run_seq();
    chk_pulses(1);
    drain();

    // bit pattern across all fields
    mark();
    add_hit(30'b100000_10101010_11001100_00001111);
    run_seq();
    chk_pulses(1);
    drain();

    // three queued hits in one freeze episode
    mark();
    for (int i = 0; i < 3; i++) add_hit(30'($urandom()));
    run_seq();
    chk_pulses(3);
    drain();

    // enable low: pending token is ignored until enable returns
    enable = 1'b0;
    add_hit(30'($urandom()));
    repeat (50) @(negedge clk);
    chk("gated_busy",   {31'd0, busy},   32'd0);
    chk("gated_freeze", {31'd0, freeze}, 32'd0);
    enable = 1'b1;
    run_seq();
    drain();

    // enable dropped mid-sequence: sequence still completes
    mark();
    add_hit(30'($urandom()));
    add_hit(30'($urandom()));
    start_seq();
    enable = 1'b0;
    finish_seq();
    chk_pulses(2);
    repeat (20) @(negedge clk);
    chk("noen_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    drain();

    // overflow: FIFO_DEPTH+5 hits with the consumer stalled
    for (int i = 0; i < FIFO_DEPTH + 5; i++) add_hit(30'($urandom()));
    run_seq();
    chk("ovf_lost", {24'd0, lost_count}, lost_exp);

    // write into the full FIFO on the very cycle a word is popped
    add_hit(30'($urandom()));
    start_seq();
    wait_read();
    repeat (DATA_DLY + 30) @(negedge clk);
    fifo_ready = 1'b1;
    @(negedge clk);
    fifo_ready = 1'b0;
    exp_q.delete(0);
    finish_seq();
    chk("fullpop_lost", {24'd0, lost_count}, lost_exp);
    drain();

    // lost_count saturation
    for (int i = 0; i < 270; i++) add_hit(30'($urandom()));
    run_seq();
    chk("sat_lost", {24'd0, lost_count}, lost_exp);
    drain();

    // reset in the middle of SHIFT, with a word already queued
    add_hit(30'($urandom()));
    run_seq();
    chk("pre_rst_valid", {31'd0, fifo_valid}, 32'd1);
    add_hit(30'($urandom()));
    start_seq();
    wait_read();
    repeat (DATA_DLY + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_read",   {31'd0, read},       32'd0);
    chk("arst_freeze", {31'd0, freeze},     32'd0);
    chk("arst_valid",  {31'd0, fifo_valid}, 32'd0);
    chk("arst_busy",   {31'd0, busy},       32'd0);
    chk("arst_lost",   {24'd0, lost_count}, 32'd0);
    exp_q.delete();
    pend_q.delete();
    lost_exp = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("post_rst_valid", {31'd0, fifo_valid}, 32'd0);
    chk("post_rst_busy",  {31'd0, busy},       32'd0);

    // clean hit after recovery
    mark();
    add_hit(30'($urandom()));
    run_seq();
    chk_pulses(1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
